// File: rtl/uart_tx_seq_wb_if.sv
// Wishbone master-side bundle for the simpleuart transmit sequencer.
interface uart_tx_seq_wb_if;
  logic [3:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/uart_tx_seq_wb.sv
// Wishbone master that programs the simpleuart divider after reset and on request,
// then streams bytes from a local FIFO to the UART data register, with a bus timeout.
module uart_tx_seq_wb #(
  parameter int DEPTH       = 16,
  parameter int DEFAULT_DIV = 868,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        div_set,
  input  logic [31:0] div_value,
  input  logic        err_clr,
  output logic        busy,
  output logic        timeout_err,
  uart_tx_seq_wb_if.master wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {INIT, IDLE, WR_DIV, WR_DAT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count_nx;
  logic          pend, pend_nx;
  logic [31:0]   pend_val;
  logic [TW-1:0] tmo_cnt;
  logic          push, pop, ack_ev, tmo_ev, end_ev;
  logic          start_div, start_dat, empty, cyc_nx, full_nx;
  logic [7:0]    head;
  logic          unused;

  assign unused    = ^wb.wbm_dat_i;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign push      = in_valid & in_ready;
  assign ack_ev    = wb.wbm_cyc_o & wb.wbm_ack_i;
  assign tmo_ev    = wb.wbm_cyc_o & ~wb.wbm_ack_i & (tmo_cnt == TW'(TIMEOUT - 1));
  assign end_ev    = ack_ev | tmo_ev;
  // A timed-out data write still pops its byte so the stream keeps moving.
  assign pop       = (state == WR_DAT) & end_ev;
  assign start_div = (state == INIT) | ((state == IDLE) & pend);
  assign start_dat = (state == IDLE) & ~pend & ~empty;
  assign cyc_nx    = start_div | start_dat | (wb.wbm_cyc_o & ~end_ev);
  assign pend_nx   = div_set | (pend & (state != IDLE));
  assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};
  assign count_nx  = wr_ptr_nx - rd_ptr_nx;
  assign full_nx   = (count_nx == (AW + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= INIT;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pend         <= 1'b0;
      pend_val     <= '0;
      tmo_cnt      <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      wb.wbm_adr_o <= '0;
      wb.wbm_dat_o <= '0;
      wb.wbm_sel_o <= '0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      rd_ptr       <= rd_ptr_nx;
      in_ready     <= ~full_nx;
      busy         <= (count_nx != '0) | pend_nx | cyc_nx;
      pend         <= pend_nx;
      wb.wbm_cyc_o <= cyc_nx;
      wb.wbm_stb_o <= cyc_nx;
      wb.wbm_we_o  <= cyc_nx;
      if (div_set) pend_val <= div_value;
      // A fresh timeout outranks a simultaneous clear.
      if (tmo_ev)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      case (state)
        INIT: begin
          state        <= WR_DIV;
          tmo_cnt      <= '0;
          wb.wbm_adr_o <= 4'h0;
          wb.wbm_dat_o <= 32'(DEFAULT_DIV);
          wb.wbm_sel_o <= 4'hF;
        end
        IDLE: begin
          tmo_cnt <= '0;
          if (pend) begin
            state        <= WR_DIV;
            wb.wbm_adr_o <= 4'h0;
            wb.wbm_dat_o <= pend_val;
            wb.wbm_sel_o <= 4'hF;
          end else if (!empty) begin
            state        <= WR_DAT;
            wb.wbm_adr_o <= 4'h4;
            wb.wbm_dat_o <= {24'h0, head};
            wb.wbm_sel_o <= 4'h1;
          end
        end
        default: begin
          if (end_ev) state   <= IDLE;
          else        tmo_cnt <= tmo_cnt + TW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_seq_wb.sv
// Scoreboard bench for uart_tx_seq_wb: a Wishbone slave model with configurable
// wait states acks writes, and every completed write is checked against a queue.
module tb_uart_tx_seq_wb;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        div_set = 1'b0;
  logic [31:0] div_value = 32'h0;
  logic        err_clr = 1'b0;
  logic        in_ready, busy, timeout_err;

  uart_tx_seq_wb_if wbif();

  uart_tx_seq_wb #(.DEPTH(16), .DEFAULT_DIV(868), .TIMEOUT(1024)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div_set(div_set), .div_value(div_value), .err_clr(err_clr),
    .busy(busy), .timeout_err(timeout_err),
    .wb(wbif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  ack_en = 1'b1;
  int  wait_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
    end
  endtask

  // Slave model and write monitor; ack is updated on the falling edge.
  initial begin
    int          ack_cnt;
    bit          last_cyc, gap_pend;
    logic [31:0] cap_dat;
    logic [3:0]  cap_adr, cap_sel;
    wr_t         e;
    ack_cnt  = 0;
    last_cyc = 1'b0;
    gap_pend = 1'b0;
    cap_dat  = '0;
    cap_adr  = '0;
    cap_sel  = '0;
    wbif.wbm_ack_i = 1'b0;
    wbif.wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (gap_pend) begin
        check_eq("gap_cyc_low", wbif.wbm_cyc_o, 0);
        gap_pend = 1'b0;
      end
      check_eq("stb_eq_cyc", wbif.wbm_stb_o, wbif.wbm_cyc_o);
      if (wbif.wbm_cyc_o) begin
        if (!last_cyc) begin
          cap_adr = wbif.wbm_adr_o;
          cap_dat = wbif.wbm_dat_o;
          cap_sel = wbif.wbm_sel_o;
        end else begin
          check_eq("hold_adr", wbif.wbm_adr_o, cap_adr);
          check_eq("hold_dat", wbif.wbm_dat_o, cap_dat);
          check_eq("hold_sel", wbif.wbm_sel_o, cap_sel);
        end
        check_eq("we", wbif.wbm_we_o, 1);
        ack_cnt++;
        wbif.wbm_ack_i = ack_en && (ack_cnt > wait_n);
        if (wbif.wbm_ack_i) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_has_exp", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("wr_adr", wbif.wbm_adr_o, e.adr);
            check_eq("wr_dat", wbif.wbm_dat_o, e.dat);
            check_eq("wr_sel", wbif.wbm_sel_o, e.sel);
          end
          gap_pend = 1'b1;
        end
      end else begin
        ack_cnt = 0;
        wbif.wbm_ack_i = 1'b0;
      end
      last_cyc = wbif.wbm_cyc_o;
    end
  end

  task automatic drive_byte(input logic [7:0] b, input bit add_exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    if (add_exp) exp_q.push_back('{adr: 4'h4, dat: {24'h0, b}, sel: 4'h1});
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input logic level, input int budget, input string tag);
    int n = 0;
    while (wbif.wbm_cyc_o !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, wbif.wbm_cyc_o, level);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", wbif.wbm_cyc_o, 0);
    check_eq("rst_stb", wbif.wbm_stb_o, 0);
    check_eq("rst_we", wbif.wbm_we_o, 0);
    check_eq("rst_adr", wbif.wbm_adr_o, 0);
    check_eq("rst_dat", wbif.wbm_dat_o, 0);
    check_eq("rst_sel", wbif.wbm_sel_o, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tmo_err", timeout_err, 0);

    // Divider init after reset release
    wait_n = 0;
    ack_en = 1'b1;
    exp_q.push_back('{adr: 4'h0, dat: 32'd868, sel: 4'hF});
    resetn = 1'b1;
    wait_idle(50, "t1");
    check_eq("t1_cyc", wbif.wbm_cyc_o, 0);
    check_eq("t1_in_ready", in_ready, 1);

    // Three bytes with three wait states each
    wait_n = 3;
    drive_byte(8'h41, 1'b1);
    drive_byte(8'h42, 1'b1);
    drive_byte(8'h43, 1'b1);
    release_in();
    wait_idle(100, "t2");

    // FIFO fill with the bus stalled; the 17th byte is dropped
    wait_n = 0;
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_byte(8'(i), i < 16);
      if (i == 15) check_eq("t3_ready_before_full", in_ready, 1);
      if (i == 16) check_eq("t3_ready_full", in_ready, 0);
    end
    release_in();
    ack_en = 1'b1;
    wait_idle(200, "t3");
    check_eq("t3_ready_after", in_ready, 1);

    // Divider change while a byte is in flight; only the last value is written
    ack_en = 1'b0;
    exp_q.push_back('{adr: 4'h4, dat: 32'hAA, sel: 4'h1});
    exp_q.push_back('{adr: 4'h0, dat: 32'd217, sel: 4'hF});
    exp_q.push_back('{adr: 4'h4, dat: 32'hBB, sel: 4'h1});
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    release_in();
    wait_cyc(1'b1, 20, "t4_open");
    @(negedge clk);
    div_set   = 1'b1;
    div_value = 32'd434;
    @(negedge clk);
    div_value = 32'd217;
    @(negedge clk);
    div_set = 1'b0;
    ack_en  = 1'b1;
    wait_idle(100, "t4");

    // Timeout on a stalled data write; the next byte still goes out
    ack_en = 1'b0;
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h66, 1'b1);
    release_in();
    wait_cyc(1'b1, 20, "t5_open");
    n = 0;
    while (wbif.wbm_cyc_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ack_en = 1'b1;
    check_eq("t5_tmo_len", n, 1024);
    check_eq("t5_tmo_err_set", timeout_err, 1);
    wait_idle(100, "t5");
    check_eq("t5_tmo_err_sticky", timeout_err, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("t5_tmo_err_clr", timeout_err, 0);

    // Asynchronous reset during an open data write
    ack_en = 1'b0;
    drive_byte(8'h77, 1'b0);
    drive_byte(8'h88, 1'b0);
    release_in();
    wait_cyc(1'b1, 20, "t6_open");
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_cyc", wbif.wbm_cyc_o, 0);
    check_eq("t6_rst_stb", wbif.wbm_stb_o, 0);
    check_eq("t6_rst_in_ready", in_ready, 0);
    check_eq("t6_rst_busy", busy, 0);
    exp_q.push_back('{adr: 4'h0, dat: 32'd868, sel: 4'hF});
    ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_idle(50, "t6");
    repeat (5) @(negedge clk);
    check_eq("t6_no_stale_cyc", wbif.wbm_cyc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
